// File: rtl/bin2bcd_seq_if.sv
// Handshake bundle for bin2bcd_seq: sample in (valid/ready + hex), BCD result out
// (valid/ready + dec/sign/ovf). Producer/consumer side uses master, converter uses slave.
interface bin2bcd_seq_if #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [BIN_W-1:0]      hex;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   dec;
    logic                  sign;
    logic                  ovf;

    modport master (
        output in_valid, hex, out_ready,
        input  in_ready, out_valid, dec, sign, ovf
    );

    modport slave (
        input  in_valid, hex, out_ready,
        output in_ready, out_valid, dec, sign, ovf
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per cycle.
// Define BIN2BCD_SIGNED_EN to treat hex as two's complement with a separate sign output.
module bin2bcd_seq #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic               clk,
    input  logic               rst,
    bin2bcd_seq_if.slave       bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [BIN_W-1:0]   r_bin;
    logic [BCD_W-1:0]   r_bcd;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic               w_accept;
    logic               w_last;
    logic [BCD_W-1:0]   w_adj;
    logic [BIN_W-1:0]   w_mag;

    // NOTE: sequential state always uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state  = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        w_accept      = 1'b0;
        w_last        = (r_cnt == '0);
        case (r_state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Add-3 correction is per 4-bit digit on the pre-shift value; 9+3 still fits in a nibble.
    always_comb begin
        w_adj = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            end else begin
                w_adj[4*d +: 4] = r_bcd[4*d +: 4];
            end
        end
    end

`ifdef BIN2BCD_SIGNED_EN
    logic r_sign;
    logic w_sign_in;

    // Negation in BIN_W bits maps the most negative value onto 2^(BIN_W-1) unchanged.
    always_comb begin
        w_sign_in = bus.hex[BIN_W-1];
        w_mag     = w_sign_in ? ({BIN_W{1'b0}} - bus.hex) : bus.hex;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign <= 1'b0;
        end else if (w_accept) begin
            r_sign <= w_sign_in;
        end
    end

    assign bus.sign = r_sign;
`else
    assign w_mag    = bus.hex;
    assign bus.sign = 1'b0;
`endif

    // A 1 leaving the top digit means the value needs more than DIGITS digits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_bin <= w_mag;
            r_bcd <= '0;
            r_cnt <= CNT_W'(BIN_W - 1);
            r_ovf <= 1'b0;
        end else if (r_state == SHIFT) begin
            r_bcd <= {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
            r_bin <= {r_bin[BIN_W-2:0], 1'b0};
            r_ovf <= r_ovf | w_adj[BCD_W-1];
            if (!w_last) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign bus.dec = r_bcd;
    assign bus.ovf = r_ovf;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: a 5-digit and a 4-digit converter share one stimulus stream and
// are compared against a decimal-arithmetic reference model.
module tb_bin2bcd_seq;
    localparam int BIN_W    = 16;
    localparam int DIGITS   = 5;
    localparam int DIGITS_S = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    bin2bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS))   bus  ();
    bin2bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS_S)) bus4 ();

    assign bus4.in_valid  = bus.in_valid;
    assign bus4.hex       = bus.hex;
    assign bus4.out_ready = bus.out_ready;

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS_S)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic longint unsigned model_mag(input logic [BIN_W-1:0] v);
`ifdef BIN2BCD_SIGNED_EN
        if (v[BIN_W-1]) return (64'd1 << BIN_W) - 64'(v);
`endif
        return 64'(v);
    endfunction

    function automatic logic model_sign(input logic [BIN_W-1:0] v);
`ifdef BIN2BCD_SIGNED_EN
        return v[BIN_W-1];
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [63:0] model_dec(input longint unsigned mag, input int nd);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(mag % 10);
            mag = mag / 10;
        end
        return r;
    endfunction

    function automatic logic model_ovf(input longint unsigned mag, input int nd);
        longint unsigned lim;
        lim = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        return (mag >= lim);
    endfunction

    // One full transaction: accept, latency, result, back-pressure of 'hold' cycles, take.
    task automatic convert(input logic [BIN_W-1:0] v, input int hold, input string tag);
        int              cyc;
        longint unsigned m;
        logic [63:0]     e_dec;
        m     = model_mag(v);
        e_dec = model_dec(m, DIGITS);
        check({tag, " in_ready_idle"}, 64'(bus.in_ready), 64'(1));
        bus.hex      = v;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.hex      = BIN_W'($urandom);
        check({tag, " in_ready_busy"}, 64'(bus.in_ready), 64'(0));
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < BIN_W + 8) begin
            step();
            cyc++;
        end
        check({tag, " latency"}, 64'(cyc), 64'(BIN_W));
        check({tag, " dec"},  64'(bus.dec),   e_dec);
        check({tag, " ovf"},  64'(bus.ovf),   64'(model_ovf(m, DIGITS)));
        check({tag, " sign"}, 64'(bus.sign),  64'(model_sign(v)));
        check({tag, " dec4"}, 64'(bus4.dec),  model_dec(m, DIGITS_S));
        check({tag, " ovf4"}, 64'(bus4.ovf),  64'(model_ovf(m, DIGITS_S)));
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.hex      = BIN_W'($urandom);
            step();
        end
        check({tag, " hold_valid"}, 64'(bus.out_valid), 64'(1));
        check({tag, " hold_dec"},   64'(bus.dec),       e_dec);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({tag, " taken_valid"}, 64'(bus.out_valid), 64'(0));
        check({tag, " taken_ready"}, 64'(bus.in_ready),  64'(1));
        check({tag, " idle_dec"},    64'(bus.dec),       e_dec);
    endtask

    logic [BIN_W-1:0] edge_vals [6] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'd9999, 16'd10000};

    initial begin
        logic [BIN_W-1:0] v;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.hex       = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        check("rst in_ready",  64'(bus.in_ready),  64'(1));
        check("rst out_valid", 64'(bus.out_valid), 64'(0));
        check("rst dec",       64'(bus.dec),       64'(0));
        check("rst sign",      64'(bus.sign),      64'(0));
        check("rst ovf",       64'(bus.ovf),       64'(0));
        rst = 1'b0;
        step();

        convert(16'h3039, 0, "d3039");
        check("lit 12345", 64'(bus.dec), 64'h12345);
        convert(16'hFFFF, 10, "dFFFF");
`ifdef BIN2BCD_SIGNED_EN
        check("lit FFFF dec",  64'(bus.dec),  64'h00001);
        check("lit FFFF sign", 64'(bus.sign), 64'(1));
`else
        check("lit FFFF dec",  64'(bus.dec),  64'h65535);
        check("lit FFFF sign", 64'(bus.sign), 64'(0));
`endif
        convert(16'h0000, 1, "d0000");
        check("lit 0", 64'(bus.dec), 64'h00000);
        convert(16'd9999, 0, "d9999");
        check("lit 9999 dec4", 64'(bus4.dec), 64'h9999);
        check("lit 9999 ovf4", 64'(bus4.ovf), 64'(0));
        convert(16'd10000, 2, "d10000");
        check("lit 10000 dec4", 64'(bus4.dec), 64'h0000);
        check("lit 10000 ovf4", 64'(bus4.ovf), 64'(1));
        convert(16'h8000, 0, "d8000");
        check("lit 8000 dec", 64'(bus.dec), 64'h32768);
        convert(16'h7FFF, 0, "d7FFF");
        check("lit 7FFF dec",  64'(bus.dec),  64'h32767);
        check("lit 7FFF sign", 64'(bus.sign), 64'(0));

        // Reset during the seventh shift cycle discards the conversion.
        bus.hex      = 16'h1234;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (6) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst out_valid", 64'(bus.out_valid), 64'(0));
        check("midrst in_ready",  64'(bus.in_ready),  64'(1));
        check("midrst dec",       64'(bus.dec),       64'(0));
        check("midrst ovf",       64'(bus.ovf),       64'(0));
        convert(16'h0100, 0, "d0100");
        check("lit 256", 64'(bus.dec), 64'h00256);

        // Reset and in_valid on the same edge: the sample must not be taken.
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.hex      = 16'd5;
        step();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        check("rstvalid in_ready", 64'(bus.in_ready), 64'(1));
        step();
        check("rstvalid still_idle", 64'(bus.in_ready),  64'(1));
        check("rstvalid out_valid",  64'(bus.out_valid), 64'(0));

        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 7) == 0) v = edge_vals[$urandom_range(0, 5)];
            else                           v = BIN_W'($urandom);
            convert(v, int'($urandom_range(0, 3)), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
